// File: rtl/spi_master_xfer_if.sv
`timescale 1ns/1ps
// Word-level request/response bundle between on-chip logic and the SPI master.
interface spi_master_xfer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = 1
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [SEL_W-1:0]      tx_sel;
    logic                  tx_hold;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;

    modport master (
        output tx_valid, tx_data, tx_sel, tx_hold,
        input  tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  tx_valid, tx_data, tx_sel, tx_hold,
        output tx_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/spi_master_xfer.sv
`timescale 1ns/1ps
// Full-duplex SPI master: each accepted word becomes one DATA_WIDTH-bit transaction,
// any SPI mode, either bit order, with optional select hold across a burst.
module spi_master_xfer #(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SPI_CLK_FREQ = 10_000_000,
    parameter logic [1:0] SPI_MODE     = 2'd0,
    parameter int         SLAVE_LINES  = 1,
    parameter int         DATA_WIDTH   = 8,
    parameter bit         MSB_FIRST    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_master_xfer_if.slave       bus,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [SLAVE_LINES-1:0] ss_n
);
    localparam int DIVIDER = SYS_CLK_FREQ / (2 * SPI_CLK_FREQ);
    localparam int SEL_W   = $clog2(SLAVE_LINES) + 1;
    localparam int DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EDGE_W  = BIT_W + 1;
    localparam logic CPOL  = SPI_MODE[1];
    localparam logic CPHA  = SPI_MODE[0];

    if (DIVIDER < 1) begin : g_bad_divider
        $error("spi_master_xfer: SYS_CLK_FREQ/(2*SPI_CLK_FREQ) must be at least 1");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("spi_master_xfer: DATA_WIDTH must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, GAP, LEAD, SHIFT, TRAIL, DONE} state_e;

    function automatic logic [SLAVE_LINES-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [SLAVE_LINES-1:0] ss;
        ss = '1;
        for (int i = 0; i < SLAVE_LINES; i++)
            if (sel == SEL_W'(i)) ss[i] = 1'b0;
        return ss;
    endfunction

    // k is the position in transmit order, mapped onto the word by MSB_FIRST
    function automatic logic word_bit(input logic [DATA_WIDTH-1:0] w, input logic [BIT_W-1:0] k);
        logic [BIT_W-1:0] idx;
        idx = MSB_FIRST ? BIT_W'(DATA_WIDTH - 1) - k : k;
        return w[idx];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r, input logic b);
        return MSB_FIRST ? {r[DATA_WIDTH-2:0], b} : {b, r[DATA_WIDTH-1:1]};
    endfunction

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_word_q, tx_word_d;
    logic [DATA_WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   hold_req_q, hold_req_d;
    logic                   hold_q, hold_d;
    logic [SEL_W-1:0]       held_sel_q, held_sel_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic [SLAVE_LINES-1:0] ss_n_q, ss_n_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   half_end, edge_go;
    logic [EDGE_W-1:0]      edge_idx;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_word_d  = tx_word_q;
        rx_sh_d    = rx_sh_q;
        sel_d      = sel_q;
        hold_req_d = hold_req_q;
        hold_d     = hold_q;
        held_sel_d = held_sel_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        edge_go    = 1'b0;
        edge_idx   = edge_cnt_q;
        half_end   = (div_cnt_q == DIV_W'(DIVIDER - 1));

        if (state_q != IDLE)
            div_cnt_d = half_end ? '0 : div_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    tx_word_d  = bus.tx_data;
                    sel_d      = bus.tx_sel;
                    hold_req_d = bus.tx_hold;
                    div_cnt_d  = '0;
                    // switching targets under a held select needs a deselect gap first
                    if (hold_q && bus.tx_sel != held_sel_q) begin
                        state_d = GAP;
                        ss_n_d  = '1;
                    end else begin
                        state_d = LEAD;
                        ss_n_d  = sel_decode(bus.tx_sel);
                        mosi_d  = word_bit(bus.tx_data, '0);
                    end
                end
            end
            GAP: begin
                if (half_end) begin
                    state_d = LEAD;
                    ss_n_d  = sel_decode(sel_q);
                    mosi_d  = word_bit(tx_word_q, '0);
                end
            end
            LEAD: begin
                if (half_end) begin
                    state_d    = SHIFT;
                    sclk_d     = ~CPOL;
                    edge_go    = 1'b1;
                    edge_idx   = '0;
                    edge_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (edge_cnt_q == EDGE_W'(2 * DATA_WIDTH - 1)) begin
                        state_d = TRAIL;
                    end else begin
                        sclk_d     = ~sclk_q;
                        edge_go    = 1'b1;
                        edge_idx   = edge_cnt_q + 1'b1;
                        edge_cnt_d = edge_idx;
                    end
                end
            end
            TRAIL: begin
                if (half_end) state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
                mosi_d     = 1'b0;
                hold_d     = hold_req_q;
                held_sel_d = sel_q;
                if (!hold_req_q) ss_n_d = '1;
            end
            default: state_d = IDLE;
        endcase

        // edge_idx even = leading edge, odd = trailing edge
        if (edge_go) begin
            if (!edge_idx[0]) begin
                if (CPHA) mosi_d  = word_bit(tx_word_q, BIT_W'(edge_idx >> 1));
                else      rx_sh_d = shift_in(rx_sh_q, miso);
            end else begin
                if (CPHA)
                    rx_sh_d = shift_in(rx_sh_q, miso);
                else if (edge_idx != EDGE_W'(2 * DATA_WIDTH - 1))
                    mosi_d = word_bit(tx_word_q, BIT_W'(EDGE_W'(edge_idx + 1'b1) >> 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_word_q  <= '0;
            rx_sh_q    <= '0;
            sel_q      <= '0;
            hold_req_q <= 1'b0;
            hold_q     <= 1'b0;
            held_sel_q <= '0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_word_q  <= tx_word_d;
            rx_sh_q    <= rx_sh_d;
            sel_q      <= sel_d;
            hold_req_q <= hold_req_d;
            hold_q     <= hold_d;
            held_sel_q <= held_sel_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE) || hold_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign ss_n         = ss_n_q;
endmodule
